// File: rtl/transceiver_pkg.sv
// Shared types and widths for the coded transceiver datapath.
package transceiver_pkg;

  localparam int BYTE_W = 8;
  localparam int CODE_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MOD,
    WAIT_TX,
    GAP
  } frame_state_t;

endpackage

// File: rtl/frame_byte_fifo.sv
// Synchronous byte FIFO with show-ahead head; a push into a full FIFO is
// accepted only when a pop frees the slot on the same edge.
module frame_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/transceiver_frame_ctrl.sv
// Frame sequencer: buffers received bytes, feeds the encoder one byte per frame,
// gates the BPSK modulator for a symbol window and launches the UART echo.
module transceiver_frame_ctrl
  import transceiver_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int PIPE_LAT      = 2,
  parameter int SYMBOL_CYCLES = 256,
  parameter int GUARD_CYCLES  = 16,
  parameter int CNT_W         = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_valid,
  input  logic [BYTE_W-1:0]             rx_byte,
  output logic [BYTE_W-1:0]             enc_data,
  output logic                          mod_en,
  output logic                          tx_dv,
  input  logic                          tx_active,
  input  logic                          tx_done,
  input  logic                          clear_ovf,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              frames_sent
);

  frame_state_t      state, state_nxt;
  logic [31:0]       cnt, cnt_nxt;
  logic [BYTE_W-1:0] enc_nxt;
  logic              mod_nxt;
  logic              dv_nxt;
  logic              done_seen, done_nxt;
  logic [CNT_W-1:0]  frames_nxt;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_head;

  frame_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (rx_valid),
    .pop     (fifo_pop),
    .wr_data (rx_byte),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      enc_data    <= '0;
      mod_en      <= 1'b0;
      tx_dv       <= 1'b0;
      done_seen   <= 1'b0;
      frames_sent <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      enc_data    <= enc_nxt;
      mod_en      <= mod_nxt;
      tx_dv       <= dv_nxt;
      done_seen   <= done_nxt;
      frames_sent <= frames_nxt;
    end
  end

  // A drop in the same cycle as clear_ovf wins so no lost byte goes unreported.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (rx_valid && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enc_nxt    = enc_data;
    mod_nxt    = mod_en;
    dv_nxt     = 1'b0;
    done_nxt   = done_seen;
    frames_nxt = frames_sent;
    fifo_pop   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          enc_nxt   = fifo_head;
          cnt_nxt   = 32'(PIPE_LAT - 1);
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (cnt != 32'd0) begin
          cnt_nxt = cnt - 32'd1;
        end else if (!tx_active) begin
          mod_nxt   = 1'b1;
          dv_nxt    = 1'b1;
          done_nxt  = 1'b0;
          cnt_nxt   = 32'(SYMBOL_CYCLES - 1);
          state_nxt = MOD;
        end
      end
      MOD: begin
        if (tx_done) done_nxt = 1'b1;
        if (cnt != 32'd0) begin
          cnt_nxt = cnt - 32'd1;
        end else begin
          mod_nxt   = 1'b0;
          state_nxt = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (done_seen || tx_done) begin
          done_nxt   = 1'b0;
          frames_nxt = frames_sent + CNT_W'(1);
          if (GUARD_CYCLES == 0) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = 32'(GUARD_CYCLES - 1);
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (cnt != 32'd0) cnt_nxt = cnt - 32'd1;
        else              state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
